// File: rtl/j_jbus_seq.sv
// ----------------------------------------------------------------------------
// j_jbus_seq : Jerry external-bus cycle sequencer
//
// Takes one internal transfer request (byte / word / long, read or write) and
// runs it as one or two external bus phases. Two phases are used only for a
// long transfer on a 16-bit external bus. While a transfer runs, the block
// drives the steering controls of the downstream data/address path and then
// reports completion to the internal master.
//
// Parameters
//   TIMEOUT : cycles a phase may wait for ack before it is aborted
//   CW      : width of the timeout counter
//
// Optional feature (macro JBUS_SEQ_TIMEOUT_EN)
//   Defined   : each phase is aborted after TIMEOUT cycles without ack and
//               err_o pulses for one cycle.
//   Undefined : phases wait indefinitely and err_o is tied to 0.
//
// Ports
//   sys_clk_i      system clock, all state on the rising edge
//   reset_i        asynchronous active-high reset
//   req_i          transfer request, sampled only while idle
//   rw_i           1 = read (external -> internal), 0 = write
//   size_i         00 byte, 01 word, 10/11 long
//   a0_i           internal address bit 0 (byte lane)
//   dsp16_i        external bus is 16 bits wide
//   bigend_i       big-endian ordering of the two halves
//   ack_i          external cycle acknowledge, one cycle per phase
//   xreq_o         external cycle request, held until ack
//   seta1_o        force address bit 1 for the second half
//   ainen_o        1 = internal address passes through, 0 = latched address
//   masterdata_o   path drives the low half from latched data (writes)
//   dinlatch_o     read latch enables: [0] low half, [1] high half
//   dmuxu_o        read steering into the upper half / byte lane
//   dmuxd_o        write steering: [1] upper half, [0] high byte
//   busy_o         transfer in progress
//   done_o         one-cycle pulse on completion
//   err_o          one-cycle pulse on timeout abort
// ----------------------------------------------------------------------------
module j_jbus_seq #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic       sys_clk_i,
  input  logic       reset_i,
  input  logic       req_i,
  input  logic       rw_i,
  input  logic [1:0] size_i,
  input  logic       a0_i,
  input  logic       dsp16_i,
  input  logic       bigend_i,
  input  logic       ack_i,
  output logic       xreq_o,
  output logic       seta1_o,
  output logic       ainen_o,
  output logic       masterdata_o,
  output logic [1:0] dinlatch_o,
  output logic [1:0] dmuxu_o,
  output logic [1:0] dmuxd_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  // Write-side lane steering for a phase. 'upper' says whether this phase
  // carries the upper internal half of a split long transfer.
  function automatic logic [1:0] wr_steer(input logic       rw,
                                          input logic [1:0] sz,
                                          input logic       a0,
                                          input logic       be,
                                          input logic       two,
                                          input logic       upper);
    logic [1:0] s;
    s = 2'b00;
    if (!rw) begin
      if (two)               s = upper ? 2'b10 : 2'b00;
      else if (sz == 2'b00)  s = {1'b0, a0 ^ be};
    end
    return s;
  endfunction

  state_e     state_q;

  // Transfer attributes captured at request time; later changes on the
  // inputs have no effect on a running transfer.
  logic       rw_q;
  logic [1:0] size_q;
  logic       a0_q;
  logic       dsp16_q;
  logic       bigend_q;

  // Registered outputs
  logic       xreq_q;
  logic       seta1_q;
  logic       ainen_q;
  logic       masterdata_q;
  logic [1:0] dmuxd_q;
  logic       busy_q;
  logic       done_q;

  logic       in_phase;
  logic       two_phase;
  logic       upper_now;
  logic       timeout_hit;

  assign in_phase  = (state_q == PH0) || (state_q == PH1);
  assign two_phase = size_q[1] & dsp16_q;
  // Big-endian puts the upper half first; little-endian puts it second.
  assign upper_now = two_phase & ((state_q == PH0) ? bigend_q : ~bigend_q);

`ifdef JBUS_SEQ_TIMEOUT_EN
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          err_q;

  assign cnt_d = cnt_q + 1'b1;
  // The count reaching TIMEOUT on this edge aborts the phase; an ack in the
  // same cycle takes priority and completes normally.
  assign timeout_hit = in_phase & ~ack_i & (cnt_d == TIMEOUT_C);

  // Cleared outside phases and on every ack, so each phase starts from zero.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (!in_phase || ack_i || timeout_hit) cnt_q <= '0;
      else                                   cnt_q <= cnt_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT_C;
  assign err_o          = 1'b0;
`endif

  // Sequencer FSM with registered outputs.
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, regardless of statement order.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      rw_q         <= 1'b0;
      size_q       <= 2'b00;
      a0_q         <= 1'b0;
      dsp16_q      <= 1'b0;
      bigend_q     <= 1'b0;
      xreq_q       <= 1'b0;
      seta1_q      <= 1'b0;
      ainen_q      <= 1'b1;
      masterdata_q <= 1'b0;
      dmuxd_q      <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            state_q      <= PH0;
            rw_q         <= rw_i;
            size_q       <= size_i;
            a0_q         <= a0_i;
            dsp16_q      <= dsp16_i;
            bigend_q     <= bigend_i;
            busy_q       <= 1'b1;
            xreq_q       <= 1'b1;
            ainen_q      <= 1'b0;
            masterdata_q <= ~rw_i;
            seta1_q      <= 1'b0;
            dmuxd_q      <= wr_steer(rw_i, size_i, a0_i, bigend_i,
                                     size_i[1] & dsp16_i, bigend_i);
          end
        end

        PH0, PH1: begin
          if (ack_i) begin
            if ((state_q == PH0) && two_phase) begin
              // Second half: xreq stays up, address bit 1 forced.
              state_q <= PH1;
              seta1_q <= 1'b1;
              dmuxd_q <= wr_steer(rw_q, size_q, a0_q, bigend_q,
                                  1'b1, ~bigend_q);
            end else begin
              state_q      <= FIN;
              done_q       <= 1'b1;
              xreq_q       <= 1'b0;
              seta1_q      <= 1'b0;
              masterdata_q <= 1'b0;
              dmuxd_q      <= 2'b00;
            end
          end else if (timeout_hit) begin
            // Abort straight back to idle without a done pulse.
            state_q      <= IDLE;
            xreq_q       <= 1'b0;
            seta1_q      <= 1'b0;
            masterdata_q <= 1'b0;
            dmuxd_q      <= 2'b00;
            ainen_q      <= 1'b1;
            busy_q       <= 1'b0;
          end
        end

        FIN: begin
          // req is not looked at here; it is taken one cycle later in IDLE.
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ainen_q <= 1'b1;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Read steering is valid only during the ack cycle of a read phase.
  // NOTE: both outputs get a default first so no path through this block
  // leaves them unassigned, which would otherwise infer a latch.
  always_comb begin
    dinlatch_o = 2'b00;
    dmuxu_o    = 2'b00;
    if (in_phase && ack_i && rw_q) begin
      if (two_phase) begin
        if (upper_now) begin
          dinlatch_o = 2'b10;
          dmuxu_o    = 2'b10;
        end else begin
          dinlatch_o = 2'b01;
        end
      end else if (size_q[1]) begin
        dinlatch_o = 2'b11;
      end else if (size_q == 2'b01) begin
        dinlatch_o = 2'b01;
      end else begin
        dinlatch_o = 2'b01;
        dmuxu_o    = {1'b0, a0_q ^ bigend_q};
      end
    end
  end

  assign xreq_o       = xreq_q;
  assign seta1_o      = seta1_q;
  assign ainen_o      = ainen_q;
  assign masterdata_o = masterdata_q;
  assign dmuxd_o      = dmuxd_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_j_jbus_seq.sv
// ----------------------------------------------------------------------------
// tb_j_jbus_seq : self-checking bench for j_jbus_seq
//
// Each transfer pushes its expected per-phase steering onto a scoreboard
// queue; entries are popped and compared on each ack cycle. The bench also
// checks completion latency, idle/reset values and, when the timeout build
// is selected (JBUS_SEQ_TIMEOUT_EN), the abort behaviour.
// ----------------------------------------------------------------------------
module tb_j_jbus_seq;

  typedef struct packed {
    logic       seta1;
    logic [1:0] dinl;
    logic [1:0] dmuxu;
    logic [1:0] dmuxd;
    logic       md;
  } phase_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req, rw, a0, dsp16, bigend, ack;
  logic [1:0] size;
  logic       xreq, seta1, ainen, masterdata, busy, done, err;
  logic [1:0] dinlatch, dmuxu, dmuxd;

  int n_chk = 0;
  int n_err = 0;
  phase_t sb[$];

  always #5 clk = ~clk;

  j_jbus_seq #(.TIMEOUT(4), .CW(8)) dut (
    .sys_clk_i    (clk),
    .reset_i      (rst),
    .req_i        (req),
    .rw_i         (rw),
    .size_i       (size),
    .a0_i         (a0),
    .dsp16_i      (dsp16),
    .bigend_i     (bigend),
    .ack_i        (ack),
    .xreq_o       (xreq),
    .seta1_o      (seta1),
    .ainen_o      (ainen),
    .masterdata_o (masterdata),
    .dinlatch_o   (dinlatch),
    .dmuxu_o      (dmuxu),
    .dmuxd_o      (dmuxd),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after FIN: block must be back in IDLE.
  task automatic idle_tick();
    tick();
    ack = 1'b0;
    check("idle_xreq", xreq, 0);
    check("idle_busy", busy, 0);
    check("idle_ainen", ainen, 1);
    check("idle_done", done, 0);
    check("idle_err", err, 0);
  endtask

  // Expected steering for each phase, derived from the transfer attributes.
  task automatic push_model(input logic r, input logic [1:0] sz, input logic a,
                            input logic ds, input logic be);
    logic   two, upper;
    int     n;
    phase_t e;
    two = sz[1] & ds;
    n   = two ? 2 : 1;
    for (int p = 0; p < n; p++) begin
      upper   = two & ((p == 0) ? be : ~be);
      e       = '0;
      e.seta1 = two && (p == 1);
      e.md    = ~r;
      if (r) begin
        if (two) begin
          e.dinl  = upper ? 2'b10 : 2'b01;
          e.dmuxu = upper ? 2'b10 : 2'b00;
        end else if (sz[1]) begin
          e.dinl = 2'b11;
        end else if (sz == 2'b01) begin
          e.dinl = 2'b01;
        end else begin
          e.dinl  = 2'b01;
          e.dmuxu = {1'b0, a ^ be};
        end
      end else begin
        if (two)              e.dmuxd = upper ? 2'b10 : 2'b00;
        else if (sz == 2'b00) e.dmuxd = {1'b0, a ^ be};
      end
      sb.push_back(e);
    end
  endtask

  // Drives one transfer starting in the current IDLE cycle (cycle 1) and
  // returns in the FIN cycle.
  task automatic run_xfer(input logic r, input logic [1:0] sz, input logic a,
                          input logic ds, input logic be, input int waits,
                          input logic hold_req);
    int     cyc_n, w, exp_done, nph;
    bit     seen_done;
    phase_t e;
    push_model(r, sz, a, ds, be);
    nph      = (sz[1] & ds) ? 2 : 1;
    exp_done = 2 + nph * (waits + 1);
    req = 1'b1; rw = r; size = sz; a0 = a; dsp16 = ds; bigend = be; ack = 1'b0;
    cyc_n = 1; w = 0; seen_done = 0;
    while (!seen_done && cyc_n < 200) begin
      tick();
      cyc_n++;
      if (!hold_req) req = 1'b0;
      // Flipping the bus config mid-transfer must not matter.
      dsp16 = ~ds; bigend = ~be; rw = ~r;
      if (xreq) begin
        if (w < waits) begin
          ack = 1'b0;
          w++;
          #1;
          check("wait_dinlatch", dinlatch, 0);
        end else begin
          ack = 1'b1;
          w = 0;
          #1;
          check("ph_busy", busy, 1);
          check("ph_ainen", ainen, 0);
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            check("ph_seta1", seta1, e.seta1);
            check("ph_masterdata", masterdata, e.md);
            check("ph_dmuxd", dmuxd, e.dmuxd);
            check("ph_dinlatch", dinlatch, e.dinl);
            check("ph_dmuxu", dmuxu, e.dmuxu);
          end
        end
      end else begin
        // ack outside a phase must be ignored.
        ack = 1'b1;
        dsp16 = ds; bigend = be; rw = r;
        if (done) begin
          seen_done = 1;
          check("done_cycle", cyc_n, exp_done);
          check("fin_busy", busy, 1);
          check("fin_dinlatch", dinlatch, 0);
        end
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    check("sb_left", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; rw = 1'b0; size = 2'b00; a0 = 1'b0;
    dsp16 = 1'b0; bigend = 1'b0; ack = 1'b0;
    tick(); tick();
    check("rst_xreq", xreq, 0);
    check("rst_ainen", ainen, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_seta1", seta1, 0);
    check("rst_masterdata", masterdata, 0);
    check("rst_dinlatch", dinlatch, 0);
    check("rst_dmuxu", dmuxu, 0);
    check("rst_dmuxd", dmuxd, 0);
    rst = 1'b0;
    tick();

    // Reset in the middle of PH0 of a long read.
    req = 1'b1; rw = 1'b1; size = 2'b10; dsp16 = 1'b1; bigend = 1'b1;
    tick();
    req = 1'b0;
    check("midrst_pre_xreq", xreq, 1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_xreq", xreq, 0);
    check("midrst_ainen", ainen, 1);
    check("midrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_nodone", done, 0);
      check("midrst_noxreq", xreq, 0);
    end

    // Long read, 16-bit bus, big-endian, two wait cycles per phase.
    run_xfer(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 2, 1'b0); idle_tick();
    // Long write, 16-bit bus, little-endian, immediate ack.
    run_xfer(1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 0, 1'b0); idle_tick();
    // Byte read, a0 = 1, little-endian.
    run_xfer(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 0, 1'b0); idle_tick();
    // Long read on 32-bit bus with req held through FIN.
    run_xfer(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b1); idle_tick();
    run_xfer(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b0); idle_tick();
    // Further lane / ordering combinations.
    run_xfer(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1, 1'b0); idle_tick();
    run_xfer(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 0, 1'b0); idle_tick();
    run_xfer(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1, 1'b0); idle_tick();
    run_xfer(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1, 1'b0); idle_tick();
    run_xfer(1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 0, 1'b0); idle_tick();
    run_xfer(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b0); idle_tick();
    run_xfer(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 3, 1'b0); idle_tick();

    // ack while idle must not start anything.
    ack = 1'b1;
    tick(); tick();
    check("idle_ack_xreq", xreq, 0);
    check("idle_ack_busy", busy, 0);
    ack = 1'b0;

`ifdef JBUS_SEQ_TIMEOUT_EN
    // ack never arrives: abort in the fifth cycle after entering PH0.
    req = 1'b1; rw = 1'b1; size = 2'b10; dsp16 = 1'b1; bigend = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      tick();
      req = 1'b0;
      check("to_wait_xreq", xreq, 1);
      check("to_wait_err", err, 0);
    end
    tick();
    check("to_err", err, 1);
    check("to_xreq", xreq, 0);
    check("to_done", done, 0);
    check("to_busy", busy, 0);
    check("to_ainen", ainen, 1);
    check("to_dinlatch", dinlatch, 0);
    tick();
    check("to_err_clear", err, 0);
    check("to_no_done", done, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
